st_buffer_stage: RTL

//   Store-side counterpart of the write-back load aligner: converts MA-stage stores
//   (SB/SH/SW) into word-aligned write data and byte enables, queues them in a small

---
 rtl/st_buffer_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/st_buffer_stage.sv
// Store queue between MA and data memory: aligns SB/SH/SW into word writes with byte
// enables, buffers DEPTH entries and drains them in order over a req/ack port.
module st_buffer_stage #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_st_ma,
   input  logic [1:0]    st_code_ma,
   input  logic [31:0]   st_adr_ma,
   input  logic [31:0]   st_data_ma,
   output logic          st_stall,
   output logic          misalign_err,
   output logic          dmem_req,
   output logic [AW-1:0] dmem_adr,
   output logic [31:0]   dmem_wdata,
   output logic [3:0]    dmem_be,
   input  logic          dmem_ack,
   input  logic [31:0]   ld_chk_adr,
   output logic          ld_hit,
   output logic          queue_empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]    r_adr   [DEPTH];
   logic [31:0]      r_wdata [DEPTH];
   logic [3:0]       r_be    [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_misalign;

   logic             w_legal;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic             w_full;
   logic             w_push;
   logic             w_reject;
   logic             w_pop;
   logic             w_hit;
   logic [AW-1:0]    w_ld_word;
   logic             w_unused;

   always_comb begin
      w_legal = 1'b0;
      w_be    = '0;
      w_wdata = '0;
      case (st_code_ma)
         2'b00: begin
            w_legal = 1'b1;
            w_be    = 4'b0001 << st_adr_ma[1:0];
            w_wdata = {4{st_data_ma[7:0]}};
         end
         2'b01: begin
            w_legal = ~st_adr_ma[0];
            w_be    = st_adr_ma[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{st_data_ma[15:0]}};
         end
         2'b10: begin
            w_legal = (st_adr_ma[1:0] == 2'b00);
            w_be    = 4'b1111;
            w_wdata = st_data_ma;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   // A full queue blocks pushes even when the head pops in the same cycle.
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_push    = cmd_st_ma & w_legal & ~w_full;
   assign w_reject  = cmd_st_ma & ~w_legal & ~w_full;
   assign w_pop     = dmem_req & dmem_ack;
   assign w_ld_word = ld_chk_adr[AW+1:2];
   assign w_unused  = ^{ld_chk_adr, st_adr_ma};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_vld      <= '0;
         r_misalign <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_adr[i]   <= '0;
            r_wdata[i] <= '0;
            r_be[i]    <= '0;
         end
      end else begin
         r_misalign <= w_reject;
         if (w_push) begin
            r_adr[r_wr_ptr]   <= st_adr_ma[AW+1:2];
            r_wdata[r_wr_ptr] <= w_wdata;
            r_be[r_wr_ptr]    <= w_be;
            r_vld[r_wr_ptr]   <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Conservative word-granular match; the head still counts in its pop cycle.
   always_comb begin
      w_hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_adr[i] == w_ld_word)) begin
            w_hit = 1'b1;
         end
      end
   end

   assign dmem_req     = (r_count != '0);
   assign dmem_adr     = dmem_req ? r_adr[r_rd_ptr]   : '0;
   assign dmem_wdata   = dmem_req ? r_wdata[r_rd_ptr] : '0;
   assign dmem_be      = dmem_req ? r_be[r_rd_ptr]    : '0;
   assign st_stall     = w_full;
   assign queue_empty  = (r_count == '0);
   assign misalign_err = r_misalign;
   assign ld_hit       = w_hit;

endmodule
